// File: rtl/lisnoc_dma_request_arbtable.sv
// Request table for the DMA engine: per-entry FREE/PENDING/ACTIVE/DONE tracking with a
// round-robin offer of PENDING entries to the control unit.
module lisnoc_dma_request_arbtable #(
    parameter int unsigned ENTRIES    = 4,
    parameter int unsigned REQ_WIDTH  = 96,
    parameter bit          IRQ_ENABLE = 1'b1,
    localparam int unsigned PTRW      = $clog2(ENTRIES),
    localparam int unsigned BEW       = REQ_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQ_WIDTH-1:0]   if_write_req,
    input  logic [PTRW-1:0]        if_write_pos,
    input  logic [BEW-1:0]         if_write_be,
    input  logic                   if_write_en,
    input  logic [PTRW-1:0]        if_valid_pos,
    input  logic                   if_valid_en,
    input  logic                   if_valid_set,
    input  logic                   if_ack_en,
    output logic                   ctrl_req_valid,
    output logic [PTRW-1:0]        ctrl_req_pos,
    output logic [REQ_WIDTH-1:0]   ctrl_req,
    input  logic                   ctrl_req_ready,
    input  logic [PTRW-1:0]        ctrl_done_pos,
    input  logic                   ctrl_done_en,
    output logic [ENTRIES-1:0]     valid,
    output logic [ENTRIES-1:0]     done,
    output logic [ENTRIES-1:0]     irq,
    output logic [PTRW:0]          occupancy,
    output logic [2*ENTRIES-1:0]   o_dbg_state,
    output logic [PTRW-1:0]        o_dbg_rr_ptr
);

    // Handshake: an offer is taken when ctrl_req_valid && ctrl_req_ready on a rising edge;
    // the offer may change freely while ctrl_req_ready is low.
    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DONE    = 2'd3
    } entry_state_t;

    entry_state_t           r_state [ENTRIES];
    logic [REQ_WIDTH-1:0]   r_payload [ENTRIES];
    logic [PTRW-1:0]        r_rr_ptr;
    logic [PTRW:0]          r_occupancy;

    entry_state_t           w_state_next [ENTRIES];
    logic [PTRW:0]          w_occ_next;
    logic                   w_found;
    logic [PTRW-1:0]        w_pos;
    logic                   w_handshake;

    function automatic logic [PTRW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= ENTRIES) s = s - ENTRIES;
        return s[PTRW-1:0];
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_found && r_state[wrap_idx(32'(r_rr_ptr), i)] == ST_PENDING) begin
                w_found = 1'b1;
                w_pos   = wrap_idx(32'(r_rr_ptr), i);
            end
        end
    end

    assign ctrl_req_valid = w_found;
    assign ctrl_req_pos   = w_pos;
    assign ctrl_req       = w_found ? r_payload[w_pos] : '0;
    assign w_handshake    = w_found & ctrl_req_ready;

    // Same-entry priorities: handshake beats cancel, start beats ack on a DONE entry.
    always_comb begin
        w_occ_next = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_state_next[e] = r_state[e];
            case (r_state[e])
                ST_FREE: begin
                    if (if_valid_en && if_valid_set && if_valid_pos == PTRW'(e))
                        w_state_next[e] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (w_handshake && w_pos == PTRW'(e))
                        w_state_next[e] = ST_ACTIVE;
                    else if (if_valid_en && !if_valid_set && if_valid_pos == PTRW'(e))
                        w_state_next[e] = ST_FREE;
                end
                ST_ACTIVE: begin
                    if (ctrl_done_en && ctrl_done_pos == PTRW'(e))
                        w_state_next[e] = ST_DONE;
                end
                ST_DONE: begin
                    if (if_valid_en && if_valid_set && if_valid_pos == PTRW'(e))
                        w_state_next[e] = ST_PENDING;
                    else if (if_ack_en && if_valid_pos == PTRW'(e))
                        w_state_next[e] = ST_FREE;
                end
                default: w_state_next[e] = ST_FREE;
            endcase
            if (w_state_next[e] != ST_FREE)
                w_occ_next = w_occ_next + (PTRW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) r_state[e] <= ST_FREE;
            r_rr_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) r_state[e] <= w_state_next[e];
            r_occupancy <= w_occ_next;
            if (w_handshake)
                r_rr_ptr <= wrap_idx(32'(w_pos), 1);
        end
    end

    // Payload is deliberately left out of reset; only FREE or DONE entries accept writes.
    always_ff @(posedge clk) begin
        if (!rst && if_write_en) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (if_write_pos == PTRW'(e) &&
                    (r_state[e] == ST_FREE || r_state[e] == ST_DONE)) begin
                    for (int b = 0; b < BEW; b++) begin
                        if (if_write_be[b])
                            r_payload[e][8*b +: 8] <= if_write_req[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            valid[e]            = (r_state[e] == ST_PENDING) || (r_state[e] == ST_ACTIVE);
            done[e]             = (r_state[e] == ST_DONE);
            irq[e]              = IRQ_ENABLE && (r_state[e] == ST_DONE);
            o_dbg_state[2*e +: 2] = r_state[e];
        end
    end

    assign occupancy    = r_occupancy;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_lisnoc_dma_request_arbtable.sv
// Directed bench for lisnoc_dma_request_arbtable with ENTRIES=4, REQ_WIDTH=96.
module tb_lisnoc_dma_request_arbtable;
  localparam int ENTRIES = 4;
  localparam int REQ_WIDTH = 96;
  localparam int PTRW = 2;
  localparam int BEW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REQ_WIDTH-1:0] if_write_req = '0;
  logic [PTRW-1:0] if_write_pos = '0;
  logic [BEW-1:0] if_write_be = '0;
  logic if_write_en = 1'b0;
  logic [PTRW-1:0] if_valid_pos = '0;
  logic if_valid_en = 1'b0;
  logic if_valid_set = 1'b0;
  logic if_ack_en = 1'b0;
  logic ctrl_req_valid;
  logic [PTRW-1:0] ctrl_req_pos;
  logic [REQ_WIDTH-1:0] ctrl_req;
  logic ctrl_req_ready = 1'b0;
  logic [PTRW-1:0] ctrl_done_pos = '0;
  logic ctrl_done_en = 1'b0;
  logic [ENTRIES-1:0] valid, done, irq;
  logic [PTRW:0] occupancy;
  logic [2*ENTRIES-1:0] o_dbg_state;
  logic [PTRW-1:0] o_dbg_rr_ptr;

  int checks = 0;
  int errors = 0;

  localparam logic [REQ_WIDTH-1:0] P0 = 96'h0000_1111_2222_3333_4444_5555;
  localparam logic [REQ_WIDTH-1:0] P1 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [REQ_WIDTH-1:0] P2 = 96'hCAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [REQ_WIDTH-1:0] PAA = {12{8'hAA}};
  localparam logic [REQ_WIDTH-1:0] P55 = {12{8'h55}};
  localparam logic [REQ_WIDTH-1:0] P11 = {12{8'h11}};
  localparam logic [REQ_WIDTH-1:0] PMIX = {{11{8'hAA}}, 8'h55};

  lisnoc_dma_request_arbtable #(.ENTRIES(ENTRIES), .REQ_WIDTH(REQ_WIDTH), .IRQ_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_write_req(if_write_req), .if_write_pos(if_write_pos), .if_write_be(if_write_be),
    .if_write_en(if_write_en), .if_valid_pos(if_valid_pos), .if_valid_en(if_valid_en),
    .if_valid_set(if_valid_set), .if_ack_en(if_ack_en),
    .ctrl_req_valid(ctrl_req_valid), .ctrl_req_pos(ctrl_req_pos), .ctrl_req(ctrl_req),
    .ctrl_req_ready(ctrl_req_ready), .ctrl_done_pos(ctrl_done_pos), .ctrl_done_en(ctrl_done_en),
    .valid(valid), .done(done), .irq(irq), .occupancy(occupancy),
    .o_dbg_state(o_dbg_state), .o_dbg_rr_ptr(o_dbg_rr_ptr)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    if_write_en = 1'b0;
    if_valid_en = 1'b0;
    if_valid_set = 1'b0;
    if_ack_en = 1'b0;
    ctrl_done_en = 1'b0;
    ctrl_req_ready = 1'b0;
  endtask

  task automatic write_start(input logic [PTRW-1:0] pos, input logic [REQ_WIDTH-1:0] data,
                             input logic [BEW-1:0] be, input bit wr, input bit st);
    if_write_en = wr; if_write_pos = pos; if_write_req = data; if_write_be = be;
    if_valid_en = st; if_valid_set = 1'b1; if_valid_pos = pos;
    tick();
    idle();
  endtask

  task automatic cancel(input logic [PTRW-1:0] pos);
    if_valid_en = 1'b1; if_valid_set = 1'b0; if_valid_pos = pos;
    tick();
    idle();
  endtask

  task automatic ack(input logic [PTRW-1:0] pos);
    if_ack_en = 1'b1; if_valid_pos = pos;
    tick();
    idle();
  endtask

  task automatic finish_entry(input logic [PTRW-1:0] pos);
    ctrl_done_en = 1'b1; ctrl_done_pos = pos;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_valid", ctrl_req_valid, 0);
    check("rst_req_pos", ctrl_req_pos, 0);
    check("rst_req", ctrl_req, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);
    check("rst_occ", occupancy, 0);
    check("rst_rr", o_dbg_rr_ptr, 0);

    // first request: write + start in the same cycle, then grant
    write_start(2'd1, P1, '1, 1'b1, 1'b1);
    check("e1_occ", occupancy, 1);
    check("e1_valid", valid, 4'b0010);
    ctrl_req_ready = 1'b1;
    check("e1_offer_valid", ctrl_req_valid, 1);
    check("e1_offer_pos", ctrl_req_pos, 1);
    check("e1_offer_req", ctrl_req, P1);
    tick();
    ctrl_req_ready = 1'b0;
    check("e1_active_valid", valid, 4'b0010);
    check("e1_active_state", o_dbg_state[3:2], 2'd2);
    check("e1_no_offer", ctrl_req_valid, 0);
    check("e1_rr", o_dbg_rr_ptr, 2);

    finish_entry(2'd1);
    check("e1_done", done, 4'b0010);
    check("e1_irq", irq, 4'b0010);
    check("e1_done_valid", valid, 0);
    ack(2'd1);
    check("e1_ack_done", done, 0);
    check("e1_ack_occ", occupancy, 0);

    // byte-lane write on entry 3, then ignored write while PENDING
    write_start(2'd3, PAA, '1, 1'b1, 1'b0);
    write_start(2'd3, P55, 12'h001, 1'b1, 1'b0);
    write_start(2'd3, '0, '0, 1'b0, 1'b1);
    write_start(2'd3, P11, '1, 1'b1, 1'b0);
    write_start(2'd0, P0, '1, 1'b1, 1'b1);
    write_start(2'd2, P2, '1, 1'b1, 1'b1);
    check("rr_occ3", occupancy, 3);
    check("rr_ptr2", o_dbg_rr_ptr, 2);

    // grant order 2,3,0; cancel on entry 2 collides with its handshake
    ctrl_req_ready = 1'b1;
    if_valid_en = 1'b1; if_valid_set = 1'b0; if_valid_pos = 2'd2;
    check("g1_pos", ctrl_req_pos, 2);
    check("g1_req", ctrl_req, P2);
    tick();
    if_valid_en = 1'b0;
    check("cancel_vs_hs_state", o_dbg_state[5:4], 2'd2);
    check("g2_pos", ctrl_req_pos, 3);
    check("g2_req_bytelane", ctrl_req, PMIX);
    tick();
    check("g3_pos", ctrl_req_pos, 0);
    check("g3_req", ctrl_req, P0);
    tick();
    ctrl_req_ready = 1'b0;
    check("g_end_offer", ctrl_req_valid, 0);
    check("g_end_valid", valid, 4'b1101);
    check("g_end_occ", occupancy, 3);
    check("g_end_rr", o_dbg_rr_ptr, 1);

    // completion and acknowledge on entry 0
    finish_entry(2'd0);
    check("e0_done", done, 4'b0001);
    check("e0_irq", irq, 4'b0001);
    check("e0_valid", valid, 4'b1100);
    ack(2'd0);
    check("e0_ack_done", done, 0);
    check("e0_ack_occ", occupancy, 2);

    // strobes on wrong states are ignored
    ack(2'd2);
    cancel(2'd3);
    finish_entry(2'd1);
    check("ign_occ", occupancy, 2);
    check("ign_valid", valid, 4'b1100);
    check("ign_done", done, 0);

    // cancel a PENDING entry
    write_start(2'd0, '0, '0, 1'b0, 1'b1);
    check("pend0_occ", occupancy, 3);
    check("pend0_pos", ctrl_req_pos, 0);
    cancel(2'd0);
    check("cancel0_occ", occupancy, 2);
    check("cancel0_offer", ctrl_req_valid, 0);

    // mixed states then reset with a competing strobe
    write_start(2'd1, '0, '0, 1'b0, 1'b1);
    finish_entry(2'd3);
    check("mix_valid", valid, 4'b0110);
    check("mix_done", done, 4'b1000);
    check("mix_occ", occupancy, 3);
    rst = 1'b1;
    if_valid_en = 1'b1; if_valid_set = 1'b1; if_valid_pos = 2'd0;
    tick();
    rst = 1'b0;
    idle();
    check("rst2_valid", valid, 0);
    check("rst2_done", done, 0);
    check("rst2_irq", irq, 0);
    check("rst2_offer", ctrl_req_valid, 0);
    check("rst2_occ", occupancy, 0);
    check("rst2_state", o_dbg_state, 0);
    check("rst2_rr", o_dbg_rr_ptr, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
